regfile_seq: RTL and testbench

- Multi-cycle instruction sequencer for the processor's one-hot-selected general register file.
- Accepts one register-transfer instruction per start handshake: MV, MVI, ADD, SUB.
- Drives the register file's one-hot read/write selects (sel, sel2), its write strobe (is_in), the write-bus source mux, and the ALU result-register controls.
- Sits between the instruction fetch/decode logic and the register file/ALU datapath.

---
 rtl/regfile_seq_if.sv | 30 +++
 rtl/regfile_seq.sv | 160 ++++++++++++++++
 tb/tb_regfile_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_if.sv
// Control link between decode logic (master) and the register-file sequencer (slave).
// The master issues instructions; the slave returns register-file and ALU controls.
interface regfile_seq_if #(
    parameter int SIZE = 32,
    parameter int AW   = 5
);
    logic            start;
    logic [1:0]      op;
    logic [AW-1:0]   rx;
    logic [AW-1:0]   ry;
    logic [SIZE-1:0] sel;
    logic [SIZE-1:0] sel2;
    logic            is_in;
    logic [1:0]      bus_src;
    logic            g_load;
    logic            alu_sub;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, op, rx, ry,
        input  sel, sel2, is_in, bus_src, g_load, alu_sub, busy, done, err
    );

    modport slave (
        input  start, op, rx, ry,
        output sel, sel2, is_in, bus_src, g_load, alu_sub, busy, done, err
    );
endinterface

// File: rtl/regfile_seq.sv
// Multi-cycle MV/MVI/ADD/SUB sequencer for a one-hot-selected register file.
// Every control output is registered from the next state and next latched fields.
module regfile_seq #(
    parameter int SIZE = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          reset,
    regfile_seq_if.slave  ctrl
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MV   = 3'd1,
        MVI  = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   rx_q, rx_d;
    logic [AW-1:0]   ry_q, ry_d;

    logic [SIZE-1:0] sel_q, sel_d;
    logic [SIZE-1:0] sel2_q, sel2_d;
    logic            is_in_q, is_in_d;
    logic [1:0]      bus_src_q, bus_src_d;
    logic            g_load_q, g_load_d;
    logic            alu_sub_q, alu_sub_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    // Out-of-range indices match no bit, so the select stays all-zero.
    function automatic logic [SIZE-1:0] onehot(input logic [AW-1:0] idx);
        logic [SIZE-1:0] v;
        v = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (idx == AW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic outOfRange(input logic [AW-1:0] idx);
        return int'(idx) >= SIZE;
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        unique case (state_q)
            IDLE: begin
                if (ctrl.start) begin
                    op_d = ctrl.op;
                    rx_d = ctrl.rx;
                    ry_d = ctrl.ry;
                    unique case (ctrl.op)
                        2'b00:   state_d = MV;
                        2'b01:   state_d = MVI;
                        default: state_d = EXEC;
                    endcase
                end
            end
            MV, MVI, WB: state_d = DONE;
            EXEC:        state_d = WB;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d     = '0;
        sel2_d    = '0;
        is_in_d   = 1'b0;
        bus_src_d = 2'b00;
        g_load_d  = 1'b0;
        alu_sub_d = 1'b0;
        busy_d    = (state_d != IDLE);
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_d)
            MV: begin
                sel_d     = onehot(rx_d);
                sel2_d    = onehot(ry_d);
                bus_src_d = 2'b01;
                is_in_d   = 1'b1;
            end
            MVI: begin
                sel_d     = onehot(rx_d);
                bus_src_d = 2'b10;
                is_in_d   = 1'b1;
            end
            EXEC: begin
                sel_d     = onehot(rx_d);
                sel2_d    = onehot(ry_d);
                g_load_d  = 1'b1;
                alu_sub_d = op_d[0];
            end
            WB: begin
                sel_d     = onehot(rx_d);
                bus_src_d = 2'b11;
                is_in_d   = 1'b1;
                alu_sub_d = op_d[0];
            end
            DONE: begin
                done_d = 1'b1;
                // MVI has no second operand, so its ry is never checked.
                err_d  = outOfRange(rx_d) || ((op_d != 2'b01) && outOfRange(ry_d));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            sel_q     <= '0;
            sel2_q    <= '0;
            is_in_q   <= 1'b0;
            bus_src_q <= 2'b00;
            g_load_q  <= 1'b0;
            alu_sub_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            sel_q     <= sel_d;
            sel2_q    <= sel2_d;
            is_in_q   <= is_in_d;
            bus_src_q <= bus_src_d;
            g_load_q  <= g_load_d;
            alu_sub_q <= alu_sub_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ctrl.sel     = sel_q;
    assign ctrl.sel2    = sel2_q;
    assign ctrl.is_in   = is_in_q;
    assign ctrl.bus_src = bus_src_q;
    assign ctrl.g_load  = g_load_q;
    assign ctrl.alu_sub = alu_sub_q;
    assign ctrl.busy    = busy_q;
    assign ctrl.done    = done_q;
    assign ctrl.err     = err_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq: a 32-entry sequencer driving a small register-file/ALU
// model, plus a 16-entry instance used for out-of-range indices.
module tb_regfile_seq;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    regfile_seq_if #(.SIZE(32), .AW(5)) ifA ();
    regfile_seq_if #(.SIZE(16), .AW(5)) ifB ();

    regfile_seq #(.SIZE(32), .AW(5)) dutA (.clk(clk), .reset(reset), .ctrl(ifA.slave));
    regfile_seq #(.SIZE(16), .AW(5)) dutB (.clk(clk), .reset(reset), .ctrl(ifB.slave));

    // Packed view of the scalar controls: is_in, bus_src, g_load, alu_sub, busy, done, err.
    wire [7:0] ctlA = {ifA.is_in, ifA.bus_src, ifA.g_load, ifA.alu_sub, ifA.busy, ifA.done, ifA.err};
    wire [7:0] ctlB = {ifB.is_in, ifB.bus_src, ifB.g_load, ifB.alu_sub, ifB.busy, ifB.done, ifB.err};

    logic [15:0] regs [32];
    logic [15:0] gReg;
    logic [15:0] tbImm;
    logic [15:0] out1, out2, busVal;
    logic [4:0]  hot1, hot2;
    logic        hot1Valid, hot2Valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        hot1 = '0;
        hot2 = '0;
        hot1Valid = 1'b0;
        hot2Valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (ifA.sel[i])  begin hot1 = 5'(i); hot1Valid = 1'b1; end
            if (ifA.sel2[i]) begin hot2 = 5'(i); hot2Valid = 1'b1; end
        end
        out1 = hot1Valid ? regs[hot1] : 16'h0;
        out2 = hot2Valid ? regs[hot2] : 16'h0;
        case (ifA.bus_src)
            2'b01:   busVal = out2;
            2'b10:   busVal = tbImm;
            2'b11:   busVal = gReg;
            default: busVal = 16'h0;
        endcase
    end

    // Register file and ALU result register, controlled only by the sequencer outputs.
    always @(posedge clk) begin
        if (ifA.g_load) gReg <= ifA.alu_sub ? (out1 - out2) : (out1 + out2);
        if (ifA.is_in && hot1Valid) regs[hot1] <= busVal;
    end

    task automatic doInstr(input logic [1:0] op, input logic [4:0] rx, input logic [4:0] ry,
                           input logic [15:0] imm);
        logic got;
        tbImm = imm;
        @(negedge clk);
        ifA.start = 1'b1; ifA.op = op; ifA.rx = rx; ifA.ry = ry;
        @(negedge clk);
        ifA.start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            if (ifA.done) got = 1'b1;
            else @(negedge clk);
        end
        assertCount++;
        if (got !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL doInstr_timeout: done seen %b, required 1", got);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        assertCount++;
        if ({ctlA, ifA.sel, ifA.sel2} !== 72'h0) begin
            failCount++;
            $display("[TB] FAIL reset_idle: got ctl=%h sel=%h sel2=%h, required all 0", ctlA, ifA.sel, ifA.sel2);
        end
        reset = 1'b1;
        doInstr(2'b01, 5'd3, 5'd0, 16'h0011);
        doInstr(2'b01, 5'd4, 5'd0, 16'h0022);
        @(negedge clk);
        ifA.start = 1'b1; ifA.op = 2'b10; ifA.rx = 5'd3; ifA.ry = 5'd4;
        @(negedge clk);
        ifA.start = 1'b0;
        assertCount++;
        if (ctlA !== 8'h14) begin
            failCount++;
            $display("[TB] FAIL reset_exec_entry: got ctl=%h, required 14", ctlA);
        end
        #2 reset = 1'b0;
        #1;
        assertCount++;
        if ({ctlA, ifA.sel, ifA.sel2} !== 72'h0) begin
            failCount++;
            $display("[TB] FAIL reset_async: got ctl=%h sel=%h sel2=%h, required all 0", ctlA, ifA.sel, ifA.sel2);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            assertCount++;
            if ({ctlA, ifA.sel} !== 40'h0) begin
                failCount++;
                $display("[TB] FAIL reset_abort_idle: got ctl=%h sel=%h, required 0", ctlA, ifA.sel);
            end
        end
        assertCount++;
        if (regs[3] !== 16'h0011) begin
            failCount++;
            $display("[TB] FAIL reset_no_write: r3=%h, required 0011", regs[3]);
        end
    endtask

    task automatic test_mvi();
        tbImm = 16'h00A5;
        @(negedge clk);
        ifA.start = 1'b1; ifA.op = 2'b01; ifA.rx = 5'd5; ifA.ry = 5'd7;
        @(negedge clk);
        ifA.start = 1'b0;
        assertCount++;
        if ({ctlA, ifA.sel, ifA.sel2} !== {8'hC4, 32'h0000_0020, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL mvi_write: ctl=%h sel=%h sel2=%h, required C4 00000020 00000000", ctlA, ifA.sel, ifA.sel2);
        end
        @(negedge clk);
        assertCount++;
        if ({ctlA, ifA.sel} !== {8'h06, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL mvi_done: ctl=%h sel=%h, required 06 00000000", ctlA, ifA.sel);
        end
        @(negedge clk);
        assertCount++;
        if (ctlA !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL mvi_idle: ctl=%h, required 00", ctlA);
        end
        assertCount++;
        if (regs[5] !== 16'h00A5) begin
            failCount++;
            $display("[TB] FAIL mvi_value: r5=%h, required 00a5", regs[5]);
        end
    endtask

    task automatic test_add();
        doInstr(2'b01, 5'd2, 5'd0, 16'd7);
        doInstr(2'b01, 5'd9, 5'd0, 16'd5);
        @(negedge clk);
        ifA.start = 1'b1; ifA.op = 2'b10; ifA.rx = 5'd2; ifA.ry = 5'd9;
        @(negedge clk);
        ifA.start = 1'b0;
        assertCount++;
        if ({ctlA, ifA.sel, ifA.sel2} !== {8'h14, 32'h0000_0004, 32'h0000_0200}) begin
            failCount++;
            $display("[TB] FAIL add_exec: ctl=%h sel=%h sel2=%h, required 14 00000004 00000200", ctlA, ifA.sel, ifA.sel2);
        end
        @(negedge clk);
        assertCount++;
        if ({ctlA, ifA.sel, ifA.sel2} !== {8'hE4, 32'h0000_0004, 32'h0}) begin
            failCount++;
            $display("[TB] FAIL add_wb: ctl=%h sel=%h sel2=%h, required E4 00000004 00000000", ctlA, ifA.sel, ifA.sel2);
        end
        @(negedge clk);
        assertCount++;
        if (ctlA !== 8'h06) begin
            failCount++;
            $display("[TB] FAIL add_done: ctl=%h, required 06", ctlA);
        end
        @(negedge clk);
        assertCount++;
        if (regs[2] !== 16'd12) begin
            failCount++;
            $display("[TB] FAIL add_result: r2=%0d, required 12", regs[2]);
        end
    endtask

    task automatic test_sub_self();
        doInstr(2'b01, 5'd6, 5'd0, 16'h1234);
        @(negedge clk);
        ifA.start = 1'b1; ifA.op = 2'b11; ifA.rx = 5'd6; ifA.ry = 5'd6;
        @(negedge clk);
        ifA.start = 1'b0;
        assertCount++;
        if ({ctlA, ifA.sel, ifA.sel2} !== {8'h1C, 32'h0000_0040, 32'h0000_0040}) begin
            failCount++;
            $display("[TB] FAIL sub_exec: ctl=%h sel=%h sel2=%h, required 1C 00000040 00000040", ctlA, ifA.sel, ifA.sel2);
        end
        @(negedge clk);
        assertCount++;
        if ({ctlA, ifA.sel} !== {8'hEC, 32'h0000_0040}) begin
            failCount++;
            $display("[TB] FAIL sub_wb: ctl=%h sel=%h, required EC 00000040", ctlA, ifA.sel);
        end
        @(negedge clk);
        @(negedge clk);
        assertCount++;
        if (regs[6] !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL sub_self_result: r6=%h, required 0000", regs[6]);
        end
    endtask

    task automatic test_back_to_back();
        int         accepts;
        int         dones;
        logic       prevBusy;
        logic [9:0] acceptMask;
        doInstr(2'b01, 5'd2, 5'd0, 16'h0055);
        doInstr(2'b01, 5'd1, 5'd0, 16'h0099);
        accepts = 0; dones = 0; prevBusy = 1'b0; acceptMask = '0;
        @(negedge clk);
        ifA.start = 1'b1; ifA.op = 2'b00; ifA.rx = 5'd1; ifA.ry = 5'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifA.busy && !prevBusy) begin
                accepts++;
                acceptMask[i] = 1'b1;
            end
            if (ifA.done) dones++;
            if (i == 0) begin
                assertCount++;
                if ({ctlA, ifA.sel, ifA.sel2} !== {8'hA4, 32'h0000_0002, 32'h0000_0004}) begin
                    failCount++;
                    $display("[TB] FAIL mv_cycle: ctl=%h sel=%h sel2=%h, required A4 00000002 00000004", ctlA, ifA.sel, ifA.sel2);
                end
            end
            prevBusy = ifA.busy;
        end
        ifA.start = 1'b0;
        assertCount++;
        if (acceptMask !== 10'h249) begin
            failCount++;
            $display("[TB] FAIL b2b_issue_slots: mask=%b, required 1001001001", acceptMask);
        end
        assertCount++;
        if (dones !== 3) begin
            failCount++;
            $display("[TB] FAIL b2b_done_count: %0d, required 3", dones);
        end
        @(negedge clk);
        @(negedge clk);
        assertCount++;
        if (ctlA !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL b2b_drain: ctl=%h, required 00", ctlA);
        end
        assertCount++;
        if (regs[1] !== 16'h0055) begin
            failCount++;
            $display("[TB] FAIL b2b_mv_value: r1=%h, required 0055", regs[1]);
        end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        ifB.start = 1'b1; ifB.op = 2'b00; ifB.rx = 5'd20; ifB.ry = 5'd1;
        @(negedge clk);
        ifB.start = 1'b0;
        assertCount++;
        if ({ctlB, ifB.sel, ifB.sel2} !== {8'hA4, 16'h0000, 16'h0002}) begin
            failCount++;
            $display("[TB] FAIL oor_mv: ctl=%h sel=%h sel2=%h, required A4 0000 0002", ctlB, ifB.sel, ifB.sel2);
        end
        @(negedge clk);
        assertCount++;
        if ({ctlB, ifB.sel} !== {8'h07, 16'h0000}) begin
            failCount++;
            $display("[TB] FAIL oor_done_err: ctl=%h sel=%h, required 07 0000", ctlB, ifB.sel);
        end
        @(negedge clk);
        assertCount++;
        if (ctlB !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL oor_idle: ctl=%h, required 00", ctlB);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset = 1'b0;
        tbImm = 16'h0;
        ifA.start = 1'b0; ifA.op = 2'b00; ifA.rx = '0; ifA.ry = '0;
        ifB.start = 1'b0; ifB.op = 2'b00; ifB.rx = '0; ifB.ry = '0;
        test_reset();
        test_mvi();
        test_add();
        test_sub_self();
        test_back_to_back();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
